// File: rtl/gauss_dualth_pkg.sv
// Shared definitions for the Gaussian + dual-threshold streaming core.
// Holds the pixel width, default geometry/normalisation, the three class
// codes produced by the threshold stage, the pipeline latency and the
// classification helper.
package gauss_dualth_pkg;

  localparam int DATA_W         = 8;
  localparam int MAX_WIDTH_DEF  = 256;
  localparam int NORM_SHIFT_DEF = 5;
  localparam int LATENCY        = 4;

  typedef logic [DATA_W-1:0] pix_t;
  // win[i][j]: i = window row (0 = oldest line), j = window column (2 = newest)
  typedef pix_t [2:0][2:0] win_t;

  localparam pix_t CLS_HIGH = 8'hFF;
  localparam pix_t CLS_MID  = 8'h80;
  localparam pix_t CLS_LOW  = 8'h00;

  function automatic pix_t classify(input pix_t g, input pix_t gth, input pix_t gtl);
    if (g >= gth)      return CLS_HIGH;
    else if (g >= gtl) return CLS_MID;
    else               return CLS_LOW;
  endfunction

endpackage

// File: rtl/gauss_dualth_if.sv
// Stream bundle for the Gaussian core: pixel input side (data/keep/last/
// valid with gauss_axi_ready back-pressure) and classified output side
// (dout/valid/last with dualth_axi_ready from downstream).
// slave  : the core
// master : the source/sink driving the core
interface gauss_dualth_if;
  import gauss_dualth_pkg::*;

  pix_t axi_data_in;
  logic axi_keep;
  logic axi_last;
  logic axi_valid;
  logic gauss_axi_ready;

  logic dualth_axi_ready;
  pix_t dualth_axi_dout;
  logic dualth_axi_valid;
  logic dualth_axi_last;

  modport slave (
    input  axi_data_in, axi_keep, axi_last, axi_valid, dualth_axi_ready,
    output gauss_axi_ready, dualth_axi_dout, dualth_axi_valid, dualth_axi_last
  );

  modport master (
    output axi_data_in, axi_keep, axi_last, axi_valid, dualth_axi_ready,
    input  gauss_axi_ready, dualth_axi_dout, dualth_axi_valid, dualth_axi_last
  );
endinterface

// File: rtl/gauss3x3_window.sv
// 3x3 sliding window generator (pipeline stage 1).
// Two line buffers hold the previous two rows; a 3x3 register window shifts
// one column per accepted pixel. col/row counters drive zero padding at the
// image top (row < 2) and left edge (col < 2).
// Ports: advance (pipeline enable), accept (pixel taken this cycle), pix,
//        last (row end) -> win, win_valid, win_last.
module gauss3x3_window
  import gauss_dualth_pkg::*;
#(
  parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
  input  logic accept,
  input  pix_t pix,
  input  logic last,
  output win_t win,
  output logic win_valid,
  output logic win_last
);

  localparam int COL_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  logic [COL_W-1:0] col;
  logic [1:0]       row;   // saturates at 2: only "has 1 / 2 rows above" matters

  pix_t lb_old  [MAX_WIDTH];  // row r-2
  pix_t lb_prev [MAX_WIDTH];  // row r-1
  pix_t tap_top, tap_mid;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can form.
  always_comb begin
    tap_top = '0;
    tap_mid = '0;
    if (row == 2'd2) tap_top = lb_old[col];
    if (row != 2'd0) tap_mid = lb_prev[col];
  end

  // NOTE: line-buffer RAM has no reset; stale contents are masked by row padding.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_old[col]  <= lb_prev[col];
      lb_prev[col] <= pix;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col       <= '0;
      row       <= '0;
      win       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (advance) begin
      win_valid <= accept;
      win_last  <= accept & last;
      if (accept) begin
        // Left padding: columns left of the image read as zero.
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= (col <= COL_W'(1)) ? '0 : win[i][1];
          win[i][1] <= (col == '0)        ? '0 : win[i][2];
        end
        win[0][2] <= tap_top;
        win[1][2] <= tap_mid;
        win[2][2] <= pix;

        if (last || col == COL_W'(MAX_WIDTH - 1)) col <= '0;
        else                                      col <= col + COL_W'(1);
        if (last && row != 2'd2) row <= row + 2'd1;
      end
    end
  end

endmodule

// File: rtl/gauss_dualth_top_core.sv
// Streaming 3x3 Gaussian convolution followed by a dual-threshold classifier.
// Pipeline (all stages enabled by downstream ready):
//   1 window/line buffers  2 products  3 sum/shift/saturate  4 threshold
// Ports: clk, rst_n, bus (stream in/out), coe_* symmetric kernel
//        coefficients, gth/gtl thresholds (sampled live).
module gauss_dualth_top_core
  import gauss_dualth_pkg::*;
#(
  parameter int MAX_WIDTH  = MAX_WIDTH_DEF,
  parameter int NORM_SHIFT = NORM_SHIFT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  gauss_dualth_if.slave  bus,
  input  pix_t           coe_00_in,
  input  pix_t           coe_01_in,
  input  pix_t           coe_02_in,
  input  pix_t           coe_11_in,
  input  pix_t           coe_12_in,
  input  pix_t           coe_22_in,
  input  pix_t           gth,
  input  pix_t           gtl
);

  logic advance, accept;
  logic unused_keep;

  assign advance             = bus.dualth_axi_ready;
  assign bus.gauss_axi_ready = rst_n & bus.dualth_axi_ready;
  assign accept              = bus.axi_valid & bus.gauss_axi_ready;
  assign unused_keep         = bus.axi_keep;

  // Stage 1
  win_t win;
  logic win_valid, win_last;

  gauss3x3_window #(.MAX_WIDTH(MAX_WIDTH)) u_window (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .accept    (accept),
    .pix       (bus.axi_data_in),
    .last      (bus.axi_last),
    .win       (win),
    .win_valid (win_valid),
    .win_last  (win_last)
  );

  // Symmetric kernel expanded to a full 3x3 matrix.
  win_t coef;
  always_comb begin
    coef       = '0;
    coef[0][0] = coe_00_in;
    coef[0][1] = coe_01_in;  coef[1][0] = coe_01_in;
    coef[0][2] = coe_02_in;  coef[2][0] = coe_02_in;
    coef[1][1] = coe_11_in;
    coef[1][2] = coe_12_in;  coef[2][1] = coe_12_in;
    coef[2][2] = coe_22_in;
  end

  // Stage 2: products
  logic [2:0][2:0][2*DATA_W-1:0] prod;
  logic prod_valid, prod_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      prod_last  <= 1'b0;
    end else if (advance) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          prod[i][j] <= (2*DATA_W)'(win[i][j]) * (2*DATA_W)'(coef[i][j]);
      prod_valid <= win_valid;
      prod_last  <= win_last;
    end
  end

  // Stage 3: sum, normalise, saturate. 9 * 255 * 255 fits in 20 bits.
  logic [19:0] sum, shifted;
  pix_t        g_next;

  always_comb begin
    sum = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum = sum + 20'(prod[i][j]);
    shifted = sum >> NORM_SHIFT;
    g_next  = (shifted > 20'(2**DATA_W - 1)) ? '1 : shifted[DATA_W-1:0];
  end

  pix_t g_q;
  logic g_valid, g_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q     <= '0;
      g_valid <= 1'b0;
      g_last  <= 1'b0;
    end else if (advance) begin
      g_q     <= g_next;
      g_valid <= prod_valid;
      g_last  <= prod_last;
    end
  end

  // Stage 4: threshold register drives the outputs directly.
  pix_t dout_q;
  logic dout_valid, dout_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
    end else if (advance) begin
      dout_q     <= classify(g_q, gth, gtl);
      dout_valid <= g_valid;
      dout_last  <= g_last;
    end
  end

  assign bus.dualth_axi_dout  = dout_q;
  assign bus.dualth_axi_valid = dout_valid;
  assign bus.dualth_axi_last  = dout_last;

endmodule

// File: tb/tb_gauss_dualth_top_core.sv
// Self-checking bench for gauss_dualth_top_core: randomized streams are
// checked against an image-level reference model through a scoreboard queue.
module tb_gauss_dualth_top_core;
  import gauss_dualth_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gauss_dualth_if bus();

  logic [7:0] coe_00, coe_01, coe_02, coe_11, coe_12, coe_22, gth, gtl;

  gauss_dualth_top_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .coe_00_in (coe_00),
    .coe_01_in (coe_01),
    .coe_02_in (coe_02),
    .coe_11_in (coe_11),
    .coe_12_in (coe_12),
    .coe_22_in (coe_22),
    .gth       (gth),
    .gtl       (gtl)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] dout;
    logic       last;
    int         issue_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] img [0:15][0:255];
  int         m_row, m_col;

  function automatic int kcoef(input int i, input int j);
    int a, b;
    a = (i < j) ? i : j;
    b = (i < j) ? j : i;
    if (a == 0 && b == 0) return int'(coe_00);
    if (a == 0 && b == 1) return int'(coe_01);
    if (a == 0 && b == 2) return int'(coe_02);
    if (a == 1 && b == 1) return int'(coe_11);
    if (a == 1 && b == 2) return int'(coe_12);
    return int'(coe_22);
  endfunction

  function automatic int pixel_at(input int rr, input int cc);
    if (rr < 0 || cc < 0) return 0;
    return int'(img[rr][cc]);
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic l);
    int   sum, g;
    exp_t e;
    img[m_row][m_col] = d;
    sum = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        sum += kcoef(i, j) * pixel_at(m_row - 2 + i, m_col - 2 + j);
    g = sum / 32;
    if (g > 255) g = 255;
    if (g >= int'(gth))      e.dout = 8'hFF;
    else if (g >= int'(gtl)) e.dout = 8'h80;
    else                     e.dout = 8'h00;
    e.last      = l;
    e.issue_cyc = cyc;
    sb.push_back(e);
    if (l) begin m_row++; m_col = 0; end
    else   m_col++;
  endtask

  // ---------------- driver ----------------
  int stall_pct  = 0;
  int bubble_pct = 0;

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic rdy);
    @(posedge clk);
    #1;
    bus.axi_valid        = v;
    bus.axi_data_in      = d;
    bus.axi_last         = l;
    bus.dualth_axi_ready = rdy;
    if (v && rdy) model_accept(d, l);
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic rdy;
    if (int'($urandom_range(99)) < bubble_pct) drive(1'b0, 8'h00, 1'b0, 1'b1);
    do begin
      rdy = (int'($urandom_range(99)) >= stall_pct);
      drive(1'b1, d, l, rdy);
    end while (!rdy);
  endtask

  task automatic drain();
    int budget = 40;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    while (sb.size() != 0 && budget > 0) begin
      drive(1'b0, 8'h00, 1'b0, 1'b1);
      budget--;
    end
    repeat (2) drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.axi_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_row = 0;
    m_col = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic send_const_rows(input int rows, input int width, input logic [7:0] p);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < width; c++)
        send(p, c == width - 1);
  endtask

  // ---------------- monitor ----------------
  logic       prev_stall = 1'b0;
  logic [7:0] prev_dout;
  logic       prev_valid, prev_last;
  logic       first_lat_pending = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", bus.gauss_axi_ready, bus.dualth_axi_ready);
      if (prev_stall) begin
        check("hold_dout",  bus.dualth_axi_dout,  prev_dout);
        check("hold_valid", bus.dualth_axi_valid, prev_valid);
        check("hold_last",  bus.dualth_axi_last,  prev_last);
      end
      if (bus.dualth_axi_valid && bus.dualth_axi_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_out: got output 0x%0h, expected none", bus.dualth_axi_dout);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("dout", bus.dualth_axi_dout, e.dout);
          check("last", bus.dualth_axi_last, e.last);
          if (first_lat_pending) begin
            check("latency", cyc - e.issue_cyc, LATENCY);
            first_lat_pending = 1'b0;
          end
        end
      end
      prev_stall = !bus.dualth_axi_ready;
      prev_dout  = bus.dualth_axi_dout;
      prev_valid = bus.dualth_axi_valid;
      prev_last  = bus.dualth_axi_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.axi_valid        = 1'b0;
    bus.axi_data_in      = 8'h00;
    bus.axi_keep         = 1'b1;
    bus.axi_last         = 1'b0;
    bus.dualth_axi_ready = 1'b1;
    {coe_00, coe_01, coe_02, coe_11, coe_12, coe_22} = {6{8'd4}};
    gth = 8'd5;
    gtl = 8'd1;
    m_row = 0;
    m_col = 0;

    // Reset state
    #3;
    check("rst_dout",  bus.dualth_axi_dout,  8'h00);
    check("rst_valid", bus.dualth_axi_valid, 1'b0);
    check("rst_last",  bus.dualth_axi_last,  1'b0);
    check("rst_ready", bus.gauss_axi_ready,  1'b0);
    do_reset();

    // Constant 100, full-width rows, first-output latency
    first_lat_pending = 1'b1;
    send_const_rows(3, 256, 8'd100);
    drain();

    // Constant 1 and constant 0
    do_reset();
    send_const_rows(3, 8, 8'd1);
    drain();
    do_reset();
    send_const_rows(2, 8, 8'd0);
    drain();

    // Border: single non-zero pixel at the top-left corner
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 8; c++)
        send((r == 0 && c == 0) ? 8'd100 : 8'd0, c == 7);
    drain();

    // Saturation
    {coe_00, coe_01, coe_02, coe_11, coe_12, coe_22} = {6{8'd255}};
    do_reset();
    send_const_rows(3, 8, 8'd255);
    drain();

    // Random image, random kernel, bubbles, stalls and a 3-cycle stall mid-row
    coe_00 = 8'($urandom_range(7)); coe_01 = 8'($urandom_range(7));
    coe_02 = 8'($urandom_range(7)); coe_11 = 8'($urandom_range(7));
    coe_12 = 8'($urandom_range(7)); coe_22 = 8'($urandom_range(7));
    gth = 8'($urandom_range(40, 200));
    gtl = 8'($urandom_range(5, 39));
    do_reset();
    stall_pct  = 20;
    bubble_pct = 20;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 16; c++) begin
        logic [7:0] p;
        p = 8'($urandom);
        if (r == 2 && c == 5) begin
          repeat (3) drive(1'b1, p, 1'b0, 1'b0);
          drive(1'b1, p, 1'b0, 1'b1);
        end else begin
          send(p, c == 15);
        end
      end
    drain();

    // Reset asserted mid-row after 100 beats
    do_reset();
    for (int k = 0; k < 100; k++) send(8'($urandom), (k % 32) == 31);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dout",  bus.dualth_axi_dout,  8'h00);
    check("midrst_valid", bus.dualth_axi_valid, 1'b0);
    check("midrst_last",  bus.dualth_axi_last,  1'b0);
    check("midrst_ready", bus.gauss_axi_ready,  1'b0);
    sb.delete();
    m_row = 0;
    m_col = 0;
    bus.axi_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 32; c++)
        send(8'($urandom), c == 31);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
